// File: rtl/timer_array_pkg.sv
// Shared definitions for the timer array: register map, CTRL/STATUS bit
// positions, mode codes, FSM state codes and the bus address decode helper.
package timer_array_pkg;

    // Register select within a channel (byte offsets 0x0, 0x4, 0x8, 0xC)
    typedef logic [1:0] reg_sel_t;
    typedef logic [3:0] ch_sel_t;

    localparam reg_sel_t REG_CTRL   = 2'd0;
    localparam reg_sel_t REG_PRESET = 2'd1;
    localparam reg_sel_t REG_COUNT  = 2'd2;
    localparam reg_sel_t REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_PSC_LSB  = 8;

    // STATUS bit positions
    localparam int STATUS_PEND_BIT = 0;

    // MODE codes
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    // Per-channel FSM state codes, also visible in STATUS[2:1]
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    typedef struct packed {
        ch_sel_t  ch;
        reg_sel_t rsel;
    } addr_fields_t;

    // Addr is already a word address, so byte-address bits [7:4] / [3:2]
    // appear here as word-address bits [5:2] / [1:0].
    function automatic addr_fields_t decode_addr(input logic [5:0] word_addr);
        addr_fields_t f;
        f.ch   = word_addr[5:2];
        f.rsel = word_addr[1:0];
        return f;
    endfunction

endpackage

// File: rtl/timer_array_if.sv
// Device-bus port of the timer array as seen from the Bridge.
interface timer_array_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/timer_array_channel.sv
// One timer channel: CTRL/PRESET/COUNT/PEND registers, prescaler and the
// IDLE -> LOAD -> CNT -> INT state machine.
module timer_array_channel #(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_we,
    input  logic        preset_we,
    input  logic        status_we,
    input  logic [31:0] din,
    output logic [31:0] ctrl_rd,
    output logic [31:0] preset_rd,
    output logic [31:0] count_rd,
    output logic [31:0] status_rd,
    output logic        irq
);
    import timer_array_pkg::*;

    logic             en;
    logic             mode;
    logic             im;
    logic [PSC_W-1:0] psc;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic [PSC_W-1:0] prescaler;
    logic             pend;
    logic [1:0]       state;

    logic tick;
    logic expire;
    logic stop;
    logic oneshot_done;
    logic en_next;

    // A tick is the last cycle of a prescaler period; PRESET=0 expires like 1
    assign tick         = (state == ST_CNT) && (prescaler == psc);
    assign expire       = tick && ((count == '0) || (count == CNT_W'(1)));
    assign stop         = ctrl_we && !din[CTRL_EN_BIT];
    assign oneshot_done = (state == ST_INT) && (mode == MODE_ONESHOT);
    // A CTRL write landing on the one-shot INT cycle overrides the auto-clear
    assign en_next      = ctrl_we ? din[CTRL_EN_BIT] : (oneshot_done ? 1'b0 : en);

    // CTRL fields: bus writes, plus EN self-clearing at the end of a one-shot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en   <= 1'b0;
            mode <= MODE_ONESHOT;
            im   <= 1'b0;
            psc  <= '0;
        end else begin
            en <= en_next;
            if (ctrl_we) begin
                mode <= din[CTRL_MODE_BIT];
                im   <= din[CTRL_IM_BIT];
                psc  <= din[CTRL_PSC_LSB +: PSC_W];
            end
        end
    end

    // PRESET only takes effect at the next LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= '0;
        end else if (preset_we) begin
            preset <= din[CNT_W-1:0];
        end
    end

    // Sticky pending flag: INT sets it and beats a same-cycle write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
        end else if ((state == ST_INT) && !stop) begin
            pend <= 1'b1;
        end else if (status_we && din[STATUS_PEND_BIT]) begin
            pend <= 1'b0;
        end
    end

    // Counting FSM; clearing EN freezes COUNT and the prescaler and returns to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            prescaler <= '0;
        end else if (stop) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_next) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count     <= preset;
                    prescaler <= '0;
                    state     <= ST_CNT;
                end
                ST_CNT: begin
                    if (tick) begin
                        prescaler <= '0;
                        if (expire) begin
                            count <= '0;
                            state <= ST_INT;
                        end else begin
                            count <= count - CNT_W'(1);
                        end
                    end else begin
                        prescaler <= prescaler + PSC_W'(1);
                    end
                end
                default: begin
                    state <= (mode == MODE_RELOAD) ? ST_LOAD : ST_IDLE;
                end
            endcase
        end
    end

    // Register read views, zero-extended to the 32-bit bus
    always_comb begin
        ctrl_rd                             = '0;
        ctrl_rd[CTRL_EN_BIT]                = en;
        ctrl_rd[CTRL_MODE_BIT]              = mode;
        ctrl_rd[CTRL_IM_BIT]                = im;
        ctrl_rd[CTRL_PSC_LSB +: PSC_W]      = psc;
    end

    assign preset_rd = 32'(preset);
    assign count_rd  = 32'(count);
    assign status_rd = {29'd0, state, pend};
    assign irq       = pend & im;

endmodule

// File: rtl/timer_array.sv
// Bank of NUM_CH independent timers on the device bus: address decode,
// per-channel write strobes, read mux and interrupt reduction.
module timer_array #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PSC_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    timer_array_if.slave      bus,
    output logic [NUM_CH-1:0] IRQ,
    output logic              IRQ_any
);
    import timer_array_pkg::*;

    addr_fields_t fields;
    ch_sel_t      ch_sel;
    reg_sel_t     reg_sel;
    logic         unused_addr;

    logic [31:0] ctrl_rd   [NUM_CH];
    logic [31:0] preset_rd [NUM_CH];
    logic [31:0] count_rd  [NUM_CH];
    logic [31:0] status_rd [NUM_CH];

    assign fields      = decode_addr(bus.Addr[5:0]);
    assign ch_sel      = fields.ch;
    assign reg_sel     = fields.rsel;
    // Upper address bits are already decoded by the Bridge
    assign unused_addr = ^bus.Addr[29:6];

    // Channels past NUM_CH never match a strobe, so their writes vanish
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_array_channel #(
            .CNT_W (CNT_W),
            .PSC_W (PSC_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .ctrl_we   (bus.WE && (ch_sel == 4'(g)) && (reg_sel == REG_CTRL)),
            .preset_we (bus.WE && (ch_sel == 4'(g)) && (reg_sel == REG_PRESET)),
            .status_we (bus.WE && (ch_sel == 4'(g)) && (reg_sel == REG_STATUS)),
            .din       (bus.Din),
            .ctrl_rd   (ctrl_rd[g]),
            .preset_rd (preset_rd[g]),
            .count_rd  (count_rd[g]),
            .status_rd (status_rd[g]),
            .irq       (IRQ[g])
        );
    end

    // Combinational read mux; unmatched channel numbers read as zero
    always_comb begin
        bus.Dout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 4'(i)) begin
                case (reg_sel)
                    REG_CTRL:   bus.Dout = ctrl_rd[i];
                    REG_PRESET: bus.Dout = preset_rd[i];
                    REG_COUNT:  bus.Dout = count_rd[i];
                    default:    bus.Dout = status_rd[i];
                endcase
            end
        end
    end

    assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_timer_array.sv
// Directed self-checking bench for timer_array (4 channels, 32-bit count, 8-bit prescaler).
module tb_timer_array;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] IRQ;
    logic              IRQ_any;
    logic [31:0]       v;

    int errors = 0;
    int checks = 0;

    timer_array_if bus();

    timer_array #(
        .NUM_CH (NUM_CH),
        .CNT_W  (32),
        .PSC_W  (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .IRQ     (IRQ),
        .IRQ_any (IRQ_any)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [29:0] addr(input int ch, input int rsel);
        return 30'(ch * 4 + rsel);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
        bus.Addr = a;
        bus.Din  = d;
        bus.WE   = 1'b1;
        @(posedge clk);
        #1;
        bus.WE   = 1'b0;
        bus.Din  = '0;
    endtask

    task automatic bus_read(input logic [29:0] a, output logic [31:0] d);
        bus.Addr = a;
        #1;
        d = bus.Dout;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        bus_read(addr(0, 0), v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_ctrl: got %0h expected 0", v); end
        bus_read(addr(0, 3), v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got %0h expected 0", v); end
        checks++; if (IRQ !== 4'h0 || IRQ_any !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b/%b expected 0000/0", IRQ, IRQ_any); end
        reset = 1'b1;
        tick(1);
        // ch3 PRESET=10 one-shot, count down to 5 then pull reset
        bus_write(addr(3, 1), 32'd10);
        bus_write(addr(3, 0), 32'h1);
        tick(6);
        bus_read(addr(3, 2), v);
        checks++; if (v !== 32'd5) begin errors++; $display("[TB] FAIL reset_midcount_pre: got %0d expected 5", v); end
        reset = 1'b0;
        #1;
        bus_read(addr(3, 2), v);
        checks++; if (v !== 32'd0) begin errors++; $display("[TB] FAIL reset_async_count: got %0d expected 0", v); end
        bus_read(addr(3, 0), v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_async_ctrl: got %0h expected 0", v); end
        bus_read(addr(3, 1), v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_async_preset: got %0h expected 0", v); end
        tick(1);
        reset = 1'b1;
        tick(3);
        bus_read(addr(3, 3), v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_stays_idle: got %0h expected 0", v); end
        bus_read(addr(3, 2), v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_count_held: got %0d expected 0", v); end
    endtask

    task automatic test_one_shot();
        logic [31:0] exp_cnt;
        bus_write(addr(0, 1), 32'd3);
        bus_write(addr(0, 0), 32'h9);
        bus_read(addr(0, 3), v);
        checks++; if (v !== 32'h2) begin errors++; $display("[TB] FAIL oneshot_load_state: got %0h expected 2", v); end
        exp_cnt = 32'd3;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            bus_read(addr(0, 2), v);
            checks++; if (v !== exp_cnt) begin errors++; $display("[TB] FAIL oneshot_count: got %0d expected %0d", v, exp_cnt); end
            exp_cnt = exp_cnt - 32'd1;
        end
        tick(1);
        bus_read(addr(0, 2), v);
        checks++; if (v !== 32'd0) begin errors++; $display("[TB] FAIL oneshot_count_zero: got %0d expected 0", v); end
        bus_read(addr(0, 3), v);
        checks++; if (v !== 32'h6) begin errors++; $display("[TB] FAIL oneshot_int_state: got %0h expected 6", v); end
        checks++; if (IRQ !== 4'h0) begin errors++; $display("[TB] FAIL oneshot_irq_early: got %b expected 0000", IRQ); end
        tick(1);
        checks++; if (IRQ !== 4'b0001 || IRQ_any !== 1'b1) begin errors++; $display("[TB] FAIL oneshot_irq: got %b/%b expected 0001/1", IRQ, IRQ_any); end
        bus_read(addr(0, 0), v);
        checks++; if (v !== 32'h8) begin errors++; $display("[TB] FAIL oneshot_en_cleared: got %0h expected 8", v); end
        bus_read(addr(0, 3), v);
        checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL oneshot_idle_pend: got %0h expected 1", v); end
    endtask

    task automatic test_auto_reload();
        bus_write(addr(1, 1), 32'd2);
        bus_write(addr(1, 0), 32'h30B);
        tick(9);
        bus_read(addr(1, 3), v);
        checks++; if (v !== 32'h6) begin errors++; $display("[TB] FAIL reload_first_int: got %0h expected 6", v); end
        tick(1);
        bus_read(addr(1, 3), v);
        checks++; if (v !== 32'h3) begin errors++; $display("[TB] FAIL reload_pend_load: got %0h expected 3", v); end
        checks++; if (IRQ[1] !== 1'b1) begin errors++; $display("[TB] FAIL reload_irq: got %b expected 1", IRQ[1]); end
        tick(1);
        bus_read(addr(1, 2), v);
        checks++; if (v !== 32'd2) begin errors++; $display("[TB] FAIL reload_count_reloaded: got %0d expected 2", v); end
        bus_write(addr(1, 3), 32'h1);
        bus_read(addr(1, 3), v);
        checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL reload_w1c: got %0h expected 4", v); end
        tick(7);
        bus_read(addr(1, 3), v);
        checks++; if (v !== 32'h6) begin errors++; $display("[TB] FAIL reload_second_int: got %0h expected 6", v); end
        tick(1);
        bus_read(addr(1, 3), v);
        checks++; if (v !== 32'h3) begin errors++; $display("[TB] FAIL reload_second_pend: got %0h expected 3", v); end
        bus_write(addr(1, 0), 32'h0);
        bus_read(addr(1, 3), v);
        checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL reload_disable: got %0h expected 1", v); end
        bus_write(addr(1, 3), 32'h1);
    endtask

    task automatic test_w1c_race();
        bus_write(addr(0, 3), 32'h1);
        bus_read(addr(0, 3), v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL race_pre_clear: got %0h expected 0", v); end
        bus_write(addr(0, 1), 32'd2);
        bus_write(addr(0, 0), 32'hB);
        tick(4);
        bus_read(addr(0, 3), v);
        checks++; if (v !== 32'h3) begin errors++; $display("[TB] FAIL race_first_pend: got %0h expected 3", v); end
        tick(3);
        bus_read(addr(0, 3), v);
        checks++; if (v !== 32'h7) begin errors++; $display("[TB] FAIL race_second_int: got %0h expected 7", v); end
        bus_write(addr(0, 3), 32'h1);
        bus_read(addr(0, 3), v);
        checks++; if (v !== 32'h3) begin errors++; $display("[TB] FAIL race_set_wins: got %0h expected 3", v); end
        bus_write(addr(0, 3), 32'h1);
        bus_read(addr(0, 3), v);
        checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL race_w1c_alone: got %0h expected 4", v); end
        checks++; if (IRQ[0] !== 1'b0) begin errors++; $display("[TB] FAIL race_irq_cleared: got %b expected 0", IRQ[0]); end
        bus_write(addr(0, 0), 32'h0);
        tick(2);
        bus_read(addr(0, 2), v);
        checks++; if (v !== 32'd2) begin errors++; $display("[TB] FAIL race_count_frozen: got %0d expected 2", v); end
        bus_read(addr(0, 3), v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL race_idle_after_stop: got %0h expected 0", v); end
    endtask

    task automatic test_mask();
        bus_write(addr(2, 1), 32'd1);
        bus_write(addr(2, 0), 32'h1);
        tick(3);
        bus_read(addr(2, 3), v);
        checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL mask_pend_set: got %0h expected 1", v); end
        checks++; if (IRQ !== 4'h0 || IRQ_any !== 1'b0) begin errors++; $display("[TB] FAIL mask_irq_masked: got %b/%b expected 0000/0", IRQ, IRQ_any); end
        bus_write(addr(2, 0), 32'h8);
        checks++; if (IRQ !== 4'b0100 || IRQ_any !== 1'b1) begin errors++; $display("[TB] FAIL mask_irq_unmasked: got %b/%b expected 0100/1", IRQ, IRQ_any); end
    endtask

    task automatic test_out_of_range();
        for (int r = 0; r < 4; r++) begin
            bus_read(addr(NUM_CH, r), v);
            checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL oor_read reg%0d: got %0h expected 0", r, v); end
        end
        bus_write(addr(NUM_CH, 0), 32'hFFFF_FFFF);
        bus_write(addr(NUM_CH, 1), 32'hFFFF_FFFF);
        bus_write(addr(NUM_CH, 3), 32'hFFFF_FFFF);
        tick(2);
        bus_read(addr(0, 0), v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL oor_ch0_ctrl: got %0h expected 0", v); end
        bus_read(addr(0, 1), v);
        checks++; if (v !== 32'd2) begin errors++; $display("[TB] FAIL oor_ch0_preset: got %0h expected 2", v); end
        bus_read(addr(2, 3), v);
        checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL oor_ch2_status: got %0h expected 1", v); end
        checks++; if (IRQ !== 4'b0100 || IRQ_any !== 1'b1) begin errors++; $display("[TB] FAIL oor_irq: got %b/%b expected 0100/1", IRQ, IRQ_any); end
        bus_write(addr(2, 3), 32'h1);
        checks++; if (IRQ !== 4'h0 || IRQ_any !== 1'b0) begin errors++; $display("[TB] FAIL oor_irq_cleared: got %b/%b expected 0000/0", IRQ, IRQ_any); end
    endtask

    initial begin
        bus.Addr = '0;
        bus.Din  = '0;
        bus.WE   = 1'b0;
        reset    = 1'b0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_w1c_race();
        test_mask();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
